// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, response
// metadata and the DEPTH-derived byte-address limit.
package dmem_arbiter_pkg;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DBG  = 1;
    localparam int unsigned ERR_W     = 1;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_BUSY = 1'b1
    } rsp_state_e;

    // Captured at accept time, presented one cycle later.
    typedef struct packed {
        logic             port;
        logic [ERR_W-1:0] err;
    } rsp_meta_t;

    // First illegal byte address for a word memory of the given depth.
    function automatic logic [63:0] addr_limit(input int unsigned depth);
        return 64'(depth) * 64'd4;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant; a tie goes to the port that did not win
// the previous accepted grant.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == 1'(PORT_CORE)) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Every grant is an accept, since the winner's ready mirrors its valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'(PORT_DBG);
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: round-robin
// grant, alignment/range check, memory strobes and a one-cycle response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(addr_limit(DEPTH));

    logic [1:0]        valid;
    logic [1:0]        grant;
    logic              accept;
    logic              sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              addr_err;
    logic              good_read;

    rsp_state_e        state_q;
    rsp_state_e        state_d;
    rsp_meta_t         meta_q;
    logic [DATA_W-1:0] rdata_q;

    assign valid = {p1_req_valid, p0_req_valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (valid),
        .grant (grant)
    );

    assign p0_req_ready = grant[0];
    assign p1_req_ready = grant[1];
    assign accept       = |grant;
    assign sel_port     = grant[1];

    // Winning request fields.
    always_comb begin
        sel_we    = p0_req_we;
        sel_addr  = p0_req_addr;
        sel_wdata = p0_req_wdata;
        if (sel_port == 1'(PORT_DBG)) begin
            sel_we    = p1_req_we;
            sel_addr  = p1_req_addr;
            sel_wdata = p1_req_wdata;
        end
    end

    // Out-of-range addresses are errors, never aliased into the array.
    assign addr_err  = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);
    assign good_read = accept && !addr_err && !sel_we;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (accept) begin
            mem_read  = !addr_err && !sel_we;
            mem_write = !addr_err && sel_we;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
        end
    end

    // Response state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RSP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response next state: stay busy only while accepts keep arriving.
    always_comb begin
        state_d = RSP_IDLE;
        case (state_q)
            RSP_IDLE: state_d = accept ? RSP_BUSY : RSP_IDLE;
            RSP_BUSY: state_d = accept ? RSP_BUSY : RSP_IDLE;
            default:  state_d = RSP_IDLE;
        endcase
    end

    // Response payload captured at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            meta_q.port <= sel_port;
            meta_q.err  <= ERR_W'(addr_err);
            rdata_q     <= good_read ? mem_rdata : '0;
        end
    end

    // Response outputs steered to the port that was granted.
    always_comb begin
        p0_rsp_valid = 1'b0;
        p0_rsp_rdata = '0;
        p0_rsp_err   = 1'b0;
        p1_rsp_valid = 1'b0;
        p1_rsp_rdata = '0;
        p1_rsp_err   = 1'b0;
        if (!rst && state_q == RSP_BUSY) begin
            if (meta_q.port == 1'(PORT_DBG)) begin
                p1_rsp_valid = 1'b1;
                p1_rsp_rdata = rdata_q;
                p1_rsp_err   = meta_q.err[0];
            end else begin
                p0_rsp_valid = 1'b1;
                p0_rsp_rdata = rdata_q;
                p0_rsp_err   = meta_q.err[0];
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios against a word memory, with a
// per-cycle reference model and literal expectations for key results.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;

    logic              clk;
    logic              rst;
    logic              p0_req_valid, p0_req_ready, p0_req_we;
    logic [ADDR_W-1:0] p0_req_addr;
    logic [DATA_W-1:0] p0_req_wdata;
    logic              p0_rsp_valid, p0_rsp_err;
    logic [DATA_W-1:0] p0_rsp_rdata;
    logic              p1_req_valid, p1_req_ready, p1_req_we;
    logic [ADDR_W-1:0] p1_req_addr;
    logic [DATA_W-1:0] p1_req_wdata;
    logic              p1_rsp_valid, p1_rsp_err;
    logic [DATA_W-1:0] p1_rsp_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_req_we    (p0_req_we),
        .p0_req_addr  (p0_req_addr),
        .p0_req_wdata (p0_req_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p0_rsp_err   (p0_rsp_err),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_req_we    (p1_req_we),
        .p1_req_addr  (p1_req_addr),
        .p1_req_wdata (p1_req_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_rdata (p1_rsp_rdata),
        .p1_rsp_err   (p1_rsp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory the arbiter drives: combinational read, clocked write.
    logic [DATA_W-1:0] mem [DEPTH];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who wins, what the memory must see, what comes back.
    typedef struct {
        bit          valid;
        bit          port;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        exp_rsp = '{valid: 1'b0, port: 1'b0, err: 1'b0, rdata: 32'h0};
    bit          prefer  = 1'b0;   // port that wins the next tie
    logic [31:0] ref_mem [int];

    always @(negedge clk) begin
        int          win;
        bit          bad, we;
        logic [31:0] a, wd;
        bit          v0, v1;

        v0 = !rst && exp_rsp.valid && !exp_rsp.port;
        v1 = !rst && exp_rsp.valid && exp_rsp.port;
        chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'(v0));
        chk("p0_rsp_err",   32'(p0_rsp_err),   32'(v0 && exp_rsp.err));
        chk("p0_rsp_rdata", p0_rsp_rdata,      v0 ? exp_rsp.rdata : 32'h0);
        chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'(v1));
        chk("p1_rsp_err",   32'(p1_rsp_err),   32'(v1 && exp_rsp.err));
        chk("p1_rsp_rdata", p1_rsp_rdata,      v1 ? exp_rsp.rdata : 32'h0);

        win = -1;
        if (!rst) begin
            if (p0_req_valid && p1_req_valid) win = int'(prefer);
            else if (p0_req_valid)            win = 0;
            else if (p1_req_valid)            win = 1;
        end
        chk("p0_req_ready", 32'(p0_req_ready), 32'(win == 0));
        chk("p1_req_ready", 32'(p1_req_ready), 32'(win == 1));

        exp_rsp.valid = 1'b0;
        if (win >= 0) begin
            we  = (win == 1) ? p1_req_we    : p0_req_we;
            a   = (win == 1) ? p1_req_addr  : p0_req_addr;
            wd  = (win == 1) ? p1_req_wdata : p0_req_wdata;
            bad = (a % 4 != 0) || (a >= DEPTH * 4);
            chk("mem_read",  32'(mem_read),  32'(!bad && !we));
            chk("mem_write", 32'(mem_write), 32'(!bad && we));
            chk("mem_addr",  mem_addr, a);
            if (!bad && we) chk("mem_wdata", mem_wdata, wd);
            exp_rsp.valid = 1'b1;
            exp_rsp.port  = (win == 1);
            exp_rsp.err   = bad;
            exp_rsp.rdata = 32'h0;
            if (!bad && !we) exp_rsp.rdata = ref_mem.exists(int'(a / 4)) ? ref_mem[int'(a / 4)] : 32'h0;
            if (!bad && we)  ref_mem[int'(a / 4)] = wd;
            prefer = (win == 0);
        end else begin
            chk("mem_read_idle",  32'(mem_read),  32'h0);
            chk("mem_write_idle", 32'(mem_write), 32'h0);
            chk("mem_addr_idle",  mem_addr,       32'h0);
            chk("mem_wdata_idle", mem_wdata,      32'h0);
        end
        if (rst) begin
            prefer        = 1'b0;
            exp_rsp.valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0;
        p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0;
    endtask

    task automatic drive0(input logic we, input logic [31:0] a, input logic [31:0] d);
        p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    endtask

    task automatic drive1(input logic we, input logic [31:0] a, input logic [31:0] d);
        p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Write then read back on port 0.
        drive0(1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_wr_ready", 32'(p0_req_ready), 32'h1);
        tick();
        drive0(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t1_rd_ready", 32'(p0_req_ready), 32'h1);
        chk("t1_wr_rsp_rdata", p0_rsp_rdata, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("t1_rsp_valid", 32'(p0_rsp_valid), 32'h1);
        chk("t1_rsp_rdata", p0_rsp_rdata, 32'hDEADBEEF);
        chk("t1_rsp_err",   32'(p0_rsp_err), 32'h0);
        tick();

        // Preload, then continuous contention alternates starting with port 0.
        drive0(1'b1, 32'h0, 32'h11);
        @(negedge clk);
        tick();
        idle();
        drive1(1'b1, 32'h4, 32'h22);
        @(negedge clk);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive0(1'b0, 32'h0, 32'h0);
            drive1(1'b0, 32'h4, 32'h0);
            @(negedge clk);
            chk("t2_grant0", 32'(p0_req_ready), 32'(i % 2 == 0));
            chk("t2_grant1", 32'(p1_req_ready), 32'(i % 2 == 1));
            if (i > 0) begin
                if (i % 2 == 1) chk("t2_p0_rdata", p0_rsp_rdata, 32'h11);
                else            chk("t2_p1_rdata", p1_rsp_rdata, 32'h22);
            end
            tick();
        end
        idle();
        @(negedge clk);
        chk("t2_last_rdata", p1_rsp_rdata, 32'h22);
        tick();

        // Misaligned and out-of-range writes on port 1.
        drive1(1'b1, 32'h6, 32'h5555AAAA);
        @(negedge clk);
        chk("t3_mis_ready", 32'(p1_req_ready), 32'h1);
        chk("t3_mis_nowrite", 32'(mem_write), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("t3_mis_err",   32'(p1_rsp_err), 32'h1);
        chk("t3_mis_rdata", p1_rsp_rdata, 32'h0);
        tick();
        drive1(1'b1, 32'h400, 32'h12345678);
        @(negedge clk);
        chk("t3_oor_nowrite", 32'(mem_write), 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("t3_oor_err", 32'(p1_rsp_err), 32'h1);
        tick();

        // Reset right after an accepted read drops the response.
        drive0(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        tick();
        rst = 1'b1;
        drive0(1'b0, 32'h0, 32'h0);
        drive1(1'b0, 32'h4, 32'h0);
        @(negedge clk);
        chk("t4_rsp_dropped", 32'(p0_rsp_valid), 32'h0);
        chk("t4_rst_ready0",  32'(p0_req_ready), 32'h0);
        chk("t4_rst_ready1",  32'(p1_req_ready), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_post_rsp",   32'(p0_rsp_valid), 32'h0);
        chk("t4_first_win",  32'(p0_req_ready), 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("t4_rdata", p0_rsp_rdata, 32'h11);
        tick();

        // Write on port 0 visible to a read on port 1 the next cycle.
        drive0(1'b1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        tick();
        idle();
        drive1(1'b0, 32'h20, 32'h0);
        @(negedge clk);
        chk("t5_ready", 32'(p1_req_ready), 32'h1);
        tick();
        idle();
        @(negedge clk);
        chk("t5_rdata", p1_rsp_rdata, 32'hCAFEF00D);
        tick();

        // Port 1 alone for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive1(1'b0, (i == 2) ? 32'h10 : 32'(i * 4), 32'h0);
            @(negedge clk);
            chk("t6_p1_ready", 32'(p1_req_ready), 32'h1);
            chk("t6_p0_ready", 32'(p0_req_ready), 32'h0);
            chk("t6_p0_rsp",   32'(p0_rsp_valid), 32'h0);
            tick();
        end
        idle();
        @(negedge clk);
        chk("t6_rdata", p1_rsp_rdata, 32'hDEADBEEF);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
